// File: rtl/mem_burst_reader.sv
// Streams a contiguous burst of RAM words out through a valid/ready port.
// Define MEM_BURST_READER_LAST_EN to add the out_last end-of-burst marker.

module mem_burst_reader_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [2:0]        count
);
  logic [DATA_W-1:0] mem [4];
  logic [1:0]        wr_ptr, rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

module mem_burst_reader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 9,
  parameter int RD_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
`ifdef MEM_BURST_READER_LAST_EN
  output logic              out_last,
`endif
  input  logic              out_ready
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W:0]   ONE_L = 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  state_t            state, state_nx;
  logic [ADDR_W:0]   remain;
  logic [RD_LATENCY:0] vld_pipe;
  logic [2:0]        fifo_cnt, inflight;
  logic              issue, push, pop, room, last_word, done_set;

  // vld_pipe[0] marks an address on the bus; bit RD_LATENCY marks q valid now.
  assign inflight  = 3'($countones(vld_pipe));
  assign push      = vld_pipe[RD_LATENCY];
  assign out_valid = (fifo_cnt != 3'd0);
  assign pop       = out_valid && out_ready;
  // Count the word leaving this cycle so a full-rate stream never stalls.
  assign room      = ({1'b0, fifo_cnt} + {1'b0, inflight}) < (4'd4 + {3'd0, pop});
  assign last_word = (state == DRAIN) && (fifo_cnt == 3'd1) && (inflight == 3'd0);

`ifdef MEM_BURST_READER_LAST_EN
  assign out_last = last_word;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && length != '0) state_nx = RUN;
      RUN:     if (remain == '0)          state_nx = DRAIN;
      DRAIN:   if (pop && last_word)      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    issue    = 1'b0;
    done_set = 1'b0;
    case (state)
      IDLE: begin
        issue    = start && (length != '0);
        done_set = start && (length == '0);
      end
      RUN:     issue    = (remain != '0) && room;
      DRAIN:   done_set = pop && last_word;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdaddress <= '0;
      remain    <= '0;
      vld_pipe  <= '0;
      done      <= 1'b0;
    end else begin
      done     <= done_set;
      vld_pipe <= {vld_pipe[RD_LATENCY-1:0], issue};
      if (issue) begin
        if (state == IDLE) begin
          rdaddress <= base_addr;
          remain    <= length - ONE_L;
        end else begin
          rdaddress <= rdaddress + ONE_A;
          remain    <= remain - ONE_L;
        end
      end
    end
  end

  mem_burst_reader_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (q),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_cnt)
  );
endmodule
